// File: rtl/mvau_input_buffer_if.sv
// Stream bundle between the activation producer, the MVAU input buffer and the MAC array.
interface mvau_input_buffer_if #(
  parameter int unsigned SIMD = 2,
  parameter int unsigned TI   = 4,
  parameter int unsigned SF_T = 3,
  parameter int unsigned NF_T = 1
);
  logic                 in_v;
  logic                 in_rdy;
  logic [SIMD*TI-1:0]   in_act;
  logic                 out_v;
  logic                 out_rdy;
  logic [SIMD*TI-1:0]   out_act;
  logic [SF_T-1:0]      out_sf;
  logic [NF_T-1:0]      out_nf;
  logic                 out_last_sf;
  logic                 out_last;

  // Producer/consumer side (drives input words, accepts output words).
  modport master (
    output in_v, in_act, out_rdy,
    input  in_rdy, out_v, out_act, out_sf, out_nf, out_last_sf, out_last
  );

  // Buffer side.
  modport slave (
    input  in_v, in_act, out_rdy,
    output in_rdy, out_v, out_act, out_sf, out_nf, out_last_sf, out_last
  );
endinterface

// File: rtl/mvau_input_buffer.sv
// MVAU input buffer: stores one activation vector while forwarding it on the
// first neuron-fold pass, then replays it NF-1 times with sf/nf tags.
module mvau_input_buffer #(
  parameter int unsigned SIMD = 2,
  parameter int unsigned TI   = 4,
  parameter int unsigned SF   = 8,
  parameter int unsigned NF   = 2,
  parameter int unsigned SF_T = (SF > 1) ? $clog2(SF) : 1,
  parameter int unsigned NF_T = (NF > 1) ? $clog2(NF) : 1
) (
  input logic               clk,
  input logic               rst_n,
  mvau_input_buffer_if.slave bus
);
  localparam int unsigned W = SIMD * TI;

  typedef enum logic {WRITE = 1'b0, READ = 1'b1} state_t;

  state_t           state;
  logic [SF_T-1:0]  sf_cnt;
  logic [NF_T-1:0]  nf_cnt;
  logic [W-1:0]     mem [SF];

  logic             out_v;
  logic [W-1:0]     out_act;
  logic [SF_T-1:0]  out_sf;
  logic [NF_T-1:0]  out_nf;
  logic             out_last_sf;
  logic             out_last;

  logic             room;
  logic             src_valid;
  logic [W-1:0]     src_act;
  logic             ld;
  logic             sf_last;
  logic             nf_last;

  // Output slot is free when empty or being drained this cycle.
  assign room      = ~out_v | bus.out_rdy;
  assign src_valid = (state == WRITE) ? bus.in_v : 1'b1;
  assign src_act   = (state == WRITE) ? bus.in_act : mem[sf_cnt];
  assign ld        = room & src_valid;
  assign sf_last   = (sf_cnt == SF_T'(SF - 1));
  assign nf_last   = (nf_cnt == NF_T'(NF - 1));

  assign bus.in_rdy      = (state == WRITE) & room;
  assign bus.out_v       = out_v;
  assign bus.out_act     = out_act;
  assign bus.out_sf      = out_sf;
  assign bus.out_nf      = out_nf;
  assign bus.out_last_sf = out_last_sf;
  assign bus.out_last    = out_last;

  // Capture each accepted word for later replay passes (storage is not reset).
  always_ff @(posedge clk) begin
    if ((state == WRITE) && ld) begin
      mem[sf_cnt] <= bus.in_act;
    end
  end

  // Output register, fold counters and WRITE/READ phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= WRITE;
      sf_cnt      <= '0;
      nf_cnt      <= '0;
      out_v       <= 1'b0;
      out_act     <= '0;
      out_sf      <= '0;
      out_nf      <= '0;
      out_last_sf <= 1'b0;
      out_last    <= 1'b0;
    end else if (ld) begin
      out_v       <= 1'b1;
      out_act     <= src_act;
      out_sf      <= sf_cnt;
      out_nf      <= nf_cnt;
      out_last_sf <= sf_last;
      out_last    <= sf_last & nf_last;
      if (sf_last) begin
        sf_cnt <= '0;
        if (nf_last) begin
          nf_cnt <= '0;
          state  <= WRITE;
        end else begin
          nf_cnt <= nf_cnt + NF_T'(1);
          state  <= READ;
        end
      end else begin
        sf_cnt <= sf_cnt + SF_T'(1);
      end
    end else if (out_v & bus.out_rdy) begin
      out_v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mvau_input_buffer.sv
// Randomized and directed bench for mvau_input_buffer against a queue-based model.
module tb_mvau_input_buffer;
  localparam int unsigned SIMD = 2;
  localparam int unsigned TI   = 4;
  localparam int unsigned W    = SIMD * TI;
  localparam int unsigned SF   = 8;
  localparam int unsigned NF   = 2;

  typedef struct {
    logic [W-1:0] act;
    int           sf;
    int           nf;
    bit           last_sf;
    bit           last;
  } item_t;

  logic clk;
  logic rst_n;

  mvau_input_buffer_if #(.SIMD(SIMD), .TI(TI), .SF_T(3), .NF_T(1)) ba ();
  mvau_input_buffer_if #(.SIMD(SIMD), .TI(TI), .SF_T(2), .NF_T(1)) bb ();

  mvau_input_buffer #(.SIMD(SIMD), .TI(TI), .SF(SF), .NF(NF), .SF_T(3), .NF_T(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ba)
  );

  mvau_input_buffer #(.SIMD(SIMD), .TI(TI), .SF(4), .NF(1), .SF_T(2), .NF_T(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  item_t        q[$];
  logic [W-1:0] vec[$];

  logic [W-1:0] log_act[$];
  int           log_nf[$];
  bit           log_last[$];
  int           log_cyc[$];

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  // One cycle on dut_a: compare against model head, drive, predict the next edge.
  task automatic step(input bit v, input logic [W-1:0] a, input bit rdy, output bit acc);
    item_t it;
    bit    exp_rdy;
    chk("out_v", 32'(ba.out_v), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_act", 32'(ba.out_act), 32'(q[0].act));
      chk("out_sf", 32'(ba.out_sf), 32'(q[0].sf));
      chk("out_nf", 32'(ba.out_nf), 32'(q[0].nf));
      chk("out_last_sf", 32'(ba.out_last_sf), 32'(q[0].last_sf));
      chk("out_last", 32'(ba.out_last), 32'(q[0].last));
    end
    ba.in_v    = v;
    ba.in_act  = a;
    ba.out_rdy = rdy;
    #1;
    acc = 1'b0;
    if (rst_n) begin
      exp_rdy = (q.size() <= 1) && (q.size() == 0 || rdy);
      chk("in_rdy", 32'(ba.in_rdy), 32'(exp_rdy));
      acc = v && exp_rdy;
      if (q.size() > 0 && rdy) begin
        log_act.push_back(q[0].act);
        log_nf.push_back(q[0].nf);
        log_last.push_back(q[0].last);
        log_cyc.push_back(cyc);
        void'(q.pop_front());
      end
      if (acc) begin
        it.act     = a;
        it.sf      = vec.size();
        it.nf      = 0;
        it.last_sf = (vec.size() == SF - 1);
        it.last    = it.last_sf && (NF == 1);
        q.push_back(it);
        vec.push_back(a);
        if (vec.size() == SF) begin
          for (int n = 1; n < NF; n++) begin
            for (int s = 0; s < SF; s++) begin
              it.act     = vec[s];
              it.sf      = s;
              it.nf      = n;
              it.last_sf = (s == SF - 1);
              it.last    = it.last_sf && (n == NF - 1);
              q.push_back(it);
            end
          end
          vec.delete();
        end
      end
    end else begin
      q.delete();
      vec.delete();
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] w, input bit toggle, output int stalls);
    bit acc;
    bit done;
    stalls = 0;
    done   = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      step(1'b1, w, toggle ? (cyc % 2 == 0) : 1'b1, acc);
      if (acc) done = 1'b1;
      else     stalls++;
    end
    if (!done) chk("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain(input bit toggle);
    bit acc;
    for (int k = 0; k < 300 && q.size() > 0; k++) begin
      step(1'b0, W'($urandom), toggle ? (cyc % 2 == 0) : 1'b1, acc);
    end
    chk("drain_timeout", 32'(q.size()), 32'(0));
  endtask

  logic [W-1:0] words_b [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    int  stalls;
    int  stall9;
    bit  acc;
    bit  found;

    rst_n      = 1'b0;
    ba.in_v    = 1'b0;
    ba.in_act  = '0;
    ba.out_rdy = 1'b0;
    bb.in_v    = 1'b0;
    bb.in_act  = '0;
    bb.out_rdy = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_out_v", 32'(ba.out_v), 32'(0));
    chk("rst_out_act", 32'(ba.out_act), 32'(0));
    chk("rst_out_sf", 32'(ba.out_sf), 32'(0));
    chk("rst_out_nf", 32'(ba.out_nf), 32'(0));
    chk("rst_out_last_sf", 32'(ba.out_last_sf), 32'(0));
    chk("rst_out_last", 32'(ba.out_last), 32'(0));
    chk("rst_in_rdy", 32'(ba.in_rdy), 32'(1));
    chk("rst_b_out_v", 32'(bb.out_v), 32'(0));
    rst_n = 1'b1;

    // T1/T2: back-to-back 1..8 then 9..16 with out_rdy held high.
    log_act.delete(); log_nf.delete(); log_last.delete(); log_cyc.delete();
    stall9 = 0;
    for (int w = 1; w <= 16; w++) begin
      send(W'(w), 1'b0, stalls);
      if (w == 9) stall9 = stalls;
    end
    drain(1'b0);
    chk("t2_in_rdy_low_clks", 32'(stall9), 32'(8));
    chk("t1_log_size", 32'(log_act.size()), 32'(32));
    for (int i = 0; i < 16 && i < log_act.size(); i++) begin
      chk("t1_act", 32'(log_act[i]), 32'((i % 8) + 1));
      chk("t1_nf", 32'(log_nf[i]), 32'(i / 8));
      chk("t1_last", 32'(log_last[i]), 32'(i == 15));
    end
    if (log_act.size() > 16) begin
      chk("t2_first_word", 32'(log_act[16]), 32'(9));
      chk("t2_no_gap", 32'(log_cyc[16] - log_cyc[15]), 32'(1));
      chk("t1_no_gap", 32'(log_cyc[8] - log_cyc[7]), 32'(1));
    end

    // T3: out_rdy toggling through both passes.
    for (int w = 0; w < SF; w++) send(W'($urandom), 1'b1, stalls);
    drain(1'b1);

    // T6: random in_v gaps, random backpressure, garbage on idle in_act.
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 2) != 0), W'($urandom), ($urandom_range(0, 3) != 0), acc);
    end

    // T5: reset while the third replay word is presented.
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (q.size() > 0 && q[0].nf == 1 && q[0].sf == 2) found = 1'b1;
      else step(1'b1, W'($urandom), 1'b1, acc);
    end
    chk("t5_reach_replay", 32'(found), 32'(1));
    rst_n = 1'b0;
    step(1'b0, W'($urandom), 1'b1, acc);
    rst_n = 1'b1;
    chk("t5_out_v", 32'(ba.out_v), 32'(0));
    chk("t5_in_rdy", 32'(ba.in_rdy), 32'(1));
    step(1'b1, 8'hA5, 1'b1, acc);
    chk("t5_accept", 32'(acc), 32'(1));
    chk("t5_new_out_v", 32'(ba.out_v), 32'(1));
    chk("t5_new_act", 32'(ba.out_act), 32'(8'hA5));
    chk("t5_new_sf", 32'(ba.out_sf), 32'(0));
    chk("t5_new_nf", 32'(ba.out_nf), 32'(0));
    drain(1'b0);

    // T4: NF=1, SF=4 instance is a one-clock registered pass-through.
    for (int k = 0; k < 10; k++) begin
      if (k >= 1 && k <= 8) begin
        chk("t4_out_v", 32'(bb.out_v), 32'(1));
        chk("t4_out_act", 32'(bb.out_act), 32'(words_b[k-1]));
        chk("t4_out_sf", 32'(bb.out_sf), 32'((k - 1) % 4));
        chk("t4_out_last", 32'(bb.out_last), 32'(k == 4 || k == 8));
      end else if (k == 9) begin
        chk("t4_out_v_end", 32'(bb.out_v), 32'(0));
      end
      bb.in_v    = (k < 8);
      bb.in_act  = (k < 8) ? words_b[k] : W'($urandom);
      bb.out_rdy = 1'b1;
      #1;
      chk("t4_in_rdy", 32'(bb.in_rdy), 32'(1));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
